id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register fed directly by the 32x64 register file's ReadData1/ReadData2.
//  Closes the same-cycle write/read hazard: WB write port values are bypassed into captured operands.
//  Supports stall (hold) and flush (bubble); outputs feed the EX-stage ALU and forwarding unit.
// PARAMETERS
//  DATA_W    64  operand/immediate width
//  REG_W     5   register index width
//  CTRL_W    12  packed EX/MEM/WB control bundle width
//  ZERO_REG  31  index of hardwired-zero register (XZR); never bypassed
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  stall          in   1       hold all outputs this cycle
//  flush          in   1       replace next captured entry with a bubble
//  in_valid       in   1       ID stage holds a real instruction
//  rd1_in         in   DATA_W  register file ReadData1
//  rd2_in         in   DATA_W  register file ReadData2
//  rn_in, rm_in   in   REG_W   ReadRegister1/ReadRegister2 indices
//  rd_in          in   REG_W   destination register index
//  imm_in         in   DATA_W  sign-extended immediate
//  ctrl_in        in   CTRL_W  decoded control bundle
//  wb_regwrite    in   1       WB stage RegWrite (same signal driving the register file)
//  wb_rd          in   REG_W   WB WriteRegister
//  wb_data        in   DATA_W  WB WriteData
//  valid_out      out  1       EX entry valid
//  op_a, op_b     out  DATA_W  captured (bypassed) operands
//  rn_out, rm_out, rd_out  out  REG_W  captured indices
//  imm_out        out  DATA_W  captured immediate
//  ctrl_out       out  CTRL_W  captured control; all-zero for bubbles
// BEHAVIOUR
//  - Single clock domain; every register updates on posedge clk only.
//  - Reset (sync, active-high): valid_out=0, op_a=op_b=imm_out=0, ctrl_out=0,
//    rn_out=rm_out=rd_out=ZERO_REG (prevents false forwarding matches downstream).
//  - Capture-time bypass (combinational, before the register):
//      a_next = (wb_regwrite && wb_rd==rn_in && rn_in!=ZERO_REG) ? wb_data : rd1_in
//      b_next = same rule with rm_in / rd2_in.
//  - Priority per edge: reset > flush > stall > load.
//      flush: valid_out=0, ctrl_out=0, rd_out=ZERO_REG; op/imm/rn/rm don't-care (drive 0).
//      stall: all outputs hold prior value; bypass NOT reapplied to held operands.
//      load : valid_out=in_valid, others take *_next/inputs; in_valid=0 forces ctrl_out=0.
//  - Latency: exactly 1 cycle from ID inputs to outputs; no combinational input->output path.
//  - Stall and flush in the same cycle: flush wins (bubble inserted, stalled entry discarded).
//  - Reset asserted mid-stall: reset wins; stall on the following cycle holds reset values.
//  - A write to ZERO_REG by WB never alters operands (register 31 reads as 0).
// CONFIGURATION
//  ID_EX_BUBBLE_CNT_EN defined: adds outputs bubble_cnt[31:0] and stall_cnt[31:0];
//    bubble_cnt += 1 on each edge with flush (or load with in_valid=0); stall_cnt += 1 on each
//    edge with stall && !flush; both cleared by reset; saturate at 32'hFFFF_FFFF (no wrap).
//  Undefined: ports and counters absent; remaining behaviour identical.
// TESTING
//  1 reset 3 cycles -> valid_out=0, ctrl_out=0, rd_out=31, op_a=op_b=0.
//  2 load rn=5, rd1_in=64'h11, wb_regwrite=1, wb_rd=5, wb_data=64'hDEAD -> op_a=64'hDEAD next cycle.
//  3 rn=31, wb_rd=31, wb_regwrite=1, wb_data=64'h7, rd1_in=0 -> op_a=0 (no ZERO_REG bypass).
//  4 load entry A (op_b=64'h22), then stall=1 for 2 cycles with new inputs -> outputs stay A.
//  5 stall=1 and flush=1 together -> valid_out=0, ctrl_out=0, rd_out=31.
//  6 ID_EX_BUBBLE_CNT_EN: 3 flushes + 2 stalls then reset -> bubble_cnt=3, stall_cnt=2, then 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with write-back bypass into the captured operands.
// Define ID_EX_BUBBLE_CNT_EN to add the bubble_cnt / stall_cnt statistics outputs.
module id_ex_stage #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int CTRL_W   = 12,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [REG_W-1:0]  rn_in,
    input  logic [REG_W-1:0]  rm_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              valid_out,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [REG_W-1:0]  rn_out,
    output logic [REG_W-1:0]  rm_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    // The register file write lands on this same edge, so its read data is stale; take WB data instead.
    always_comb begin
        a_next = rd1_in;
        b_next = rd2_in;
        if (wb_regwrite && (wb_rd == rn_in) && (rn_in != ZR)) a_next = wb_data;
        if (wb_regwrite && (wb_rd == rm_in) && (rm_in != ZR)) b_next = wb_data;
    end

    // Edge priority: reset > flush (bubble) > stall (hold, no re-bypass) > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            imm_out   <= '0;
            ctrl_out  <= '0;
            rn_out    <= ZR;
            rm_out    <= ZR;
            rd_out    <= ZR;
        end else if (flush) begin
            valid_out <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            imm_out   <= '0;
            ctrl_out  <= '0;
            rn_out    <= '0;
            rm_out    <= '0;
            rd_out    <= ZR;
        end else if (!stall) begin
            valid_out <= in_valid;
            op_a      <= a_next;
            op_b      <= b_next;
            imm_out   <= imm_in;
            ctrl_out  <= in_valid ? ctrl_in : '0;
            rn_out    <= rn_in;
            rm_out    <= rm_in;
            rd_out    <= rd_in;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic bubble_evt;
    logic stall_evt;

    assign bubble_evt = flush || (!stall && !in_valid);
    assign stall_evt  = stall && !flush;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble_evt && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
            if (stall_evt && (stall_cnt != 32'hFFFF_FFFF))   stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a reference model pushes each cycle's expected outputs to a queue
// that is popped and compared one cycle later. Counter checks follow ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_stage;

    localparam int EW = 1 + 64 + 64 + 5 + 5 + 5 + 64 + 12;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid, wb_regwrite;
    logic [63:0] rd1_in, rd2_in, imm_in, wb_data;
    logic [4:0]  rn_in, rm_in, rd_in, wb_rd;
    logic [11:0] ctrl_in;
    logic        valid_out;
    logic [63:0] op_a, op_b, imm_out;
    logic [4:0]  rn_out, rm_out, rd_out;
    logic [11:0] ctrl_out;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt;
    logic [63:0] cnt_q[$];
`endif

    logic [EW-1:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    // model state
    logic        m_valid;
    logic [63:0] m_a, m_b, m_imm;
    logic [4:0]  m_rn, m_rm, m_rd;
    logic [11:0] m_ctrl;
    logic [31:0] m_bub, m_stl;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .rn_in(rn_in), .rm_in(rm_in), .rd_in(rd_in),
        .imm_in(imm_in), .ctrl_in(ctrl_in), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data),
`ifdef ID_EX_BUBBLE_CNT_EN
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
        .valid_out(valid_out), .op_a(op_a), .op_b(op_b), .rn_out(rn_out), .rm_out(rm_out),
        .rd_out(rd_out), .imm_out(imm_out), .ctrl_out(ctrl_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic [63:0] a_n, b_n;
        a_n = (wb_regwrite && wb_rd == rn_in && rn_in != 5'd31) ? wb_data : rd1_in;
        b_n = (wb_regwrite && wb_rd == rm_in && rm_in != 5'd31) ? wb_data : rd2_in;
        if (reset) begin
            m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
            m_rn = 31; m_rm = 31; m_rd = 31; m_bub = 0; m_stl = 0;
        end else if (flush) begin
            m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
            m_rn = 0; m_rm = 0; m_rd = 31;
            if (m_bub != 32'hFFFF_FFFF) m_bub++;
        end else if (stall) begin
            if (m_stl != 32'hFFFF_FFFF) m_stl++;
        end else begin
            m_valid = in_valid; m_a = a_n; m_b = b_n; m_imm = imm_in;
            m_ctrl = in_valid ? ctrl_in : 12'h0;
            m_rn = rn_in; m_rm = rm_in; m_rd = rd_in;
            if (!in_valid && m_bub != 32'hFFFF_FFFF) m_bub++;
        end
    endtask

    // One clock: model predicts, expectation queued, DUT sampled 1 time unit after the edge.
    task automatic step();
        logic [EW-1:0] e;
        model_step();
        exp_q.push_back({m_valid, m_a, m_b, m_rn, m_rm, m_rd, m_imm, m_ctrl});
`ifdef ID_EX_BUBBLE_CNT_EN
        cnt_q.push_back({m_bub, m_stl});
`endif
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("valid_out", 64'(valid_out), 64'(e[219]));
        check("op_a",      op_a,           e[218:155]);
        check("op_b",      op_b,           e[154:91]);
        check("rn_out",    64'(rn_out),    64'(e[90:86]));
        check("rm_out",    64'(rm_out),    64'(e[85:81]));
        check("rd_out",    64'(rd_out),    64'(e[80:76]));
        check("imm_out",   imm_out,        e[75:12]);
        check("ctrl_out",  64'(ctrl_out),  64'(e[11:0]));
`ifdef ID_EX_BUBBLE_CNT_EN
        begin
            logic [63:0] c;
            c = cnt_q.pop_front();
            check("bubble_cnt", 64'(bubble_cnt), 64'(c[63:32]));
            check("stall_cnt",  64'(stall_cnt),  64'(c[31:0]));
        end
`endif
    endtask

    task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic [11:0] ctrl);
        in_valid = v; rn_in = rn; rm_in = rm; rd_in = rd;
        rd1_in = d1; rd2_in = d2; imm_in = imm; ctrl_in = ctrl;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [63:0] d);
        wb_regwrite = we; wb_rd = rd; wb_data = d;
    endtask

    initial begin
        m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
        m_rn = 0; m_rm = 0; m_rd = 0; m_bub = 0; m_stl = 0;
        reset = 1; stall = 0; flush = 0;
        set_id(1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h6, 64'h7, 12'hABC);
        set_wb(0, 5'd0, 64'h0);

        // reset held three cycles
        repeat (3) step();
        reset = 0;

        // WB bypass into op_a
        set_id(1, 5'd5, 5'd6, 5'd7, 64'h11, 64'h12, 64'h40, 12'h123);
        set_wb(1, 5'd5, 64'hDEAD);
        step();
        // bypass into op_b only
        set_id(1, 5'd8, 5'd9, 5'd10, 64'h21, 64'h22, 64'h41, 12'h456);
        set_wb(1, 5'd9, 64'hBEEF);
        step();
        // write to XZR is never bypassed
        set_id(1, 5'd31, 5'd31, 5'd4, 64'h0, 64'h0, 64'h42, 12'h789);
        set_wb(1, 5'd31, 64'h7);
        step();
        // regwrite low: no bypass even with index match
        set_id(1, 5'd3, 5'd3, 5'd3, 64'h33, 64'h34, 64'h43, 12'hFFF);
        set_wb(0, 5'd3, 64'h99);
        step();
        // invalid load zeroes control
        set_id(0, 5'd2, 5'd1, 5'd6, 64'h55, 64'h56, 64'h44, 12'hFFF);
        step();

        // entry A, then two stall cycles with fresh inputs and a live bypass
        set_wb(0, 5'd0, 64'h0);
        set_id(1, 5'd11, 5'd12, 5'd13, 64'h1A, 64'h22, 64'h45, 12'h0F0);
        step();
        stall = 1;
        set_id(1, 5'd12, 5'd11, 5'd14, 64'h77, 64'h88, 64'h46, 12'h00F);
        set_wb(1, 5'd12, 64'hCAFE);
        repeat (2) step();

        // stall and flush together: bubble
        flush = 1;
        step();
        stall = 0; flush = 0;
        set_wb(0, 5'd0, 64'h0);

        // counters: reset, 3 flushes, 2 stalls, then reset again
        reset = 1; step(); reset = 0;
        set_id(1, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h3, 12'h111);
        flush = 1; repeat (3) step(); flush = 0;
        stall = 1; repeat (2) step();
        // reset mid-stall wins, next stalled cycle holds reset values
        reset = 1; step(); reset = 0;
        step();
        stall = 0;

        // random mix
        for (int i = 0; i < 60; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 5) == 0);
            stall = ($urandom_range(0, 3) == 0);
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   12'($urandom_range(0, 4095)));
            set_wb(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0) ? rm_in :
                   (($urandom_range(0, 1) == 0) ? rn_in : 5'($urandom_range(0, 31))),
                   {$urandom, $urandom});
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
